// File: rtl/booth_mult_ctrl_pkg.sv
// Shared definitions for the radix-2 Booth multiplier slice.
// Holds operand width, iteration count, counter width and the FSM state type.
package booth_mult_ctrl_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_mult_ctrl_if.sv
// Handshake/data bundle for booth_mult_ctrl.
//   ctrl_MULT      : start pulse, operands sampled on the edge it is high
//   data_operandA  : multiplicand (two's complement)
//   data_operandB  : multiplier (two's complement)
//   data_result    : low 32 bits of the signed product
//   data_exception : product does not fit in signed 32 bits
//   data_resultRDY : one-cycle result-valid pulse
//   busy           : high while an iteration sequence is running
// master = requester (drives start/operands), slave = multiplier.
interface booth_mult_ctrl_if;
    import booth_mult_ctrl_pkg::*;

    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/booth_mult_ctrl_cla.sv
// 32-bit carry-lookahead adder: 8 groups of 4 bits; every carry inside a
// group is formed directly from the group carry-in, and group carries chain
// through group generate/propagate.
//   A, B : addends
//   cIn  : carry in
//   sum  : A + B + cIn (low 32 bits)
//   cOut : two's-complement signed overflow of the addition
module thirty_two_bit_cla (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cIn,
    output logic [31:0] sum,
    output logic        cOut
);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    assign g = A & B;
    assign p = A ^ B;

    always_comb begin : lookahead
        logic gacc;
        logic pacc;
        logic cgrp;
        c    = '0;
        gacc = 1'b0;
        pacc = 1'b1;
        cgrp = cIn;
        for (int unsigned k = 0; k < 8; k++) begin
            gacc = 1'b0;
            pacc = 1'b1;
            for (int unsigned j = 0; j < 4; j++) begin
                c[4*k+j] = gacc | (pacc & cgrp);
                gacc     = g[4*k+j] | (p[4*k+j] & gacc);
                pacc     = p[4*k+j] & pacc;
            end
            cgrp = gacc | (pacc & cgrp);
        end
        c[32] = cgrp;
    end

    assign sum  = p ^ c[31:0];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign cOut = c[32] ^ c[31];

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequential radix-2 Booth multiplier, 32 x 32 -> low 32 bits + overflow flag.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   mif   : booth_mult_ctrl_if slave (start, operands, result, exception,
//           result-ready pulse, busy)
// One iteration per clock in RUN; a single shared CLA does every add/subtract.
// A start in any state (re)loads operands and enters RUN.
module booth_mult_ctrl
    import booth_mult_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = booth_mult_ctrl_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    booth_mult_ctrl_if.slave mif
);
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] u;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic             qm1;
    logic             load;
    logic             step;
    logic             last;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] sum;
    logic             add_ovf;
    logic             msb;
    logic [WIDTH-1:0] u_nx;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] result_r;
    logic             exc_r;

    // Booth recoding: 01 adds M, 10 adds ~M+1, 00/11 adds zero (U passes through).
    always_comb begin
        add_b   = '0;
        add_cin = 1'b0;
        unique case ({q[0], qm1})
            2'b01:   add_b = m;
            2'b10: begin
                add_b   = ~m;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    thirty_two_bit_cla u_cla (
        .A    (u),
        .B    (add_b),
        .cIn  (add_cin),
        .sum  (sum),
        .cOut (add_ovf)
    );

    // True sign of the 33-bit sum is sum[31] flipped on overflow; needed when
    // M = 0x80000000 so that subtracting it does not corrupt the shifted sign.
    assign msb  = sum[WIDTH-1] ^ add_ovf;
    assign u_nx = {msb, sum[WIDTH-1:1]};
    assign q_nx = {sum[0], q[WIDTH-1:1]};
    assign last = (cnt == CNT_W'(ITER - 1));

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = mif.ctrl_MULT;
        step     = 1'b0;
        unique case (state)
            IDLE: if (load) state_nx = RUN;
            RUN: begin
                step = !load;
                if (load)      state_nx = RUN;
                else if (last) state_nx = DONE;
            end
            DONE:    state_nx = load ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m        <= '0;
            u        <= '0;
            q        <= '0;
            qm1      <= 1'b0;
            cnt      <= '0;
            result_r <= '0;
            exc_r    <= 1'b0;
        end else if (load) begin
            m   <= mif.data_operandA;
            u   <= '0;
            q   <= mif.data_operandB;
            qm1 <= 1'b0;
            cnt <= '0;
        end else if (step) begin
            u   <= u_nx;
            q   <= q_nx;
            qm1 <= q[0];
            cnt <= cnt + CNT_W'(1);
            if (last) begin
                result_r <= q_nx;
                // Product fits in 32 bits only if the upper word is pure sign extension.
                exc_r    <= (u_nx != {WIDTH{q_nx[WIDTH-1]}});
            end
        end
    end

    assign mif.data_result    = result_r;
    assign mif.data_exception = exc_r;
    assign mif.data_resultRDY = (state == DONE);
    assign mif.busy           = (state == RUN);

endmodule

// File: tb/tb_booth_mult_ctrl.sv
module tb_booth_mult_ctrl;
    logic clock = 1'b0;
    logic reset;
    int   ecount = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   last_due = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    booth_mult_ctrl_if bus();

    booth_mult_ctrl #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .mif   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) ecount <= ecount + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", name, ecount, act, exp);
        end
    endtask

    // Monitor: compare every RDY pulse against the oldest outstanding expectation.
    always @(negedge clock) begin
        if (bus.data_resultRDY === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_rdy", 64'(bus.data_resultRDY), 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("rdy_cycle", 64'(ecount), 64'(mon_e.due));
                check("result", 64'(bus.data_result), 64'(mon_e.res));
                check("exception", 64'(bus.data_exception), 64'(mon_e.exc));
            end
        end else if (sbq.size() != 0 && ecount >= sbq[0].due) begin
            mon_e = sbq.pop_front();
            check("rdy_missing", 64'(bus.data_resultRDY), 64'd1);
        end
    end

    // Called just after a negedge; start is sampled at the following posedge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit abort);
        exp_t   e;
        longint p;
        p     = longint'($signed(a)) * longint'($signed(b));
        e.res = p[31:0];
        e.exc = (p != longint'($signed(e.res)));
        e.due = ecount + 33;
        if (abort && sbq.size() != 0) sbq.delete(sbq.size() - 1);
        sbq.push_back(e);
        last_due = e.due;
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        check("busy_run", 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (ecount < last_due && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("busy_done", 64'(bus.busy), 64'd0);
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input int gap);
        issue(a, b, 1'b0);
        wait_done();
        repeat (gap) @(negedge clock);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0:       v = 32'h8000_0000;
            1:       v = 32'h7FFF_FFFF;
            2:       v = 32'h0000_0000;
            3:       v = 32'hFFFF_FFFF;
            4:       v = 32'($urandom_range(0, 255));
            5:       v = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        reset             = 1'b1;
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        repeat (3) @(negedge clock);
        check("rst_result", 64'(bus.data_result), 64'd0);
        check("rst_exception", 64'(bus.data_exception), 64'd0);
        check("rst_rdy", 64'(bus.data_resultRDY), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        // Reset must win over a start on the same edge.
        bus.ctrl_MULT = 1'b1;
        @(negedge clock);
        check("rst_over_start", 64'(bus.busy), 64'd0);
        bus.ctrl_MULT = 1'b0;
        reset         = 1'b0;
        @(negedge clock);

        op(32'd3, 32'd4, 1);
        op(32'hFFFF_FFF9, 32'd6, 1);
        op(32'h8000_0000, 32'hFFFF_FFFF, 1);
        op(32'h7FFF_FFFF, 32'd2, 1);
        op(32'h0001_0000, 32'h0001_0000, 0);
        op(32'h8000_0000, 32'h8000_0000, 2);

        // Restart ten cycles into a run; only the second operation reports.
        issue(32'd5, 32'd5, 1'b0);
        repeat (9) @(negedge clock);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done();
        repeat (2) @(negedge clock);

        // Reset mid-run discards the operation.
        issue(32'd9, 32'd9, 1'b0);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        sbq.delete();
        @(negedge clock);
        reset = 1'b0;
        check("midrst_result", 64'(bus.data_result), 64'd0);
        check("midrst_exception", 64'(bus.data_exception), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        repeat (40) @(negedge clock);
        check("midrst_no_rdy", 64'(bus.data_resultRDY), 64'd0);
        op(32'd2, 32'd3, 1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                issue(pick(), pick(), 1'b0);
                repeat ($urandom_range(1, 30)) @(negedge clock);
                issue(pick(), pick(), 1'b1);
                wait_done();
                repeat ($urandom_range(0, 2)) @(negedge clock);
            end else begin
                op(pick(), pick(), $urandom_range(0, 2));
            end
        end

        repeat (40) @(negedge clock);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/booth_mult_ctrl.md
BOOTH_MULT_CTRL -- requirements
Module: booth_mult_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; only 32 is supported.
REQ-002 Port: clock, input, 1, single clock; all state updates on the rising edge.
REQ-003 Port: reset, input, 1, synchronous, active-high reset.
REQ-004 Port: ctrl_MULT, input, 1, start pulse; operands are sampled on the edge where it is high.
REQ-005 Port: data_operandA, input, 32, multiplicand, two's complement.
REQ-006 Port: data_operandB, input, 32, multiplier, two's complement.
REQ-007 Port: data_result, output, 32, low 32 bits of the signed product.
REQ-008 Port: data_exception, output, 1, product does not fit in signed 32 bits.
REQ-009 Port: data_resultRDY, output, 1, result valid; one-cycle pulse.
REQ-010 Port: busy, output, 1, high while in state RUN.

Function
REQ-011 Algorithm: radix-2 Booth; exactly one shared 32-bit CLA adder performs every add/subtract; no other adder is used in the datapath.
REQ-012 Product register P is 65 bits: {U[31:0], Q[31:0], q_-1}; M holds the multiplicand.
REQ-013 States: IDLE, RUN, DONE.
REQ-014 IDLE: ctrl_MULT=1 at an edge loads M=A, U=0, Q=B, q_-1=0, counter=0, and moves to RUN.
REQ-015 RUN iteration (one per edge): {Q[0],q_-1}=01 computes U+M (cIn=0); 10 computes U+~M (cIn=1); 00/11 passes U through unchanged.
REQ-016 Each iteration shifts {sum, Q, q_-1} right arithmetically by 1.
REQ-017 The shifted-in MSB equals sum[31] XOR adder signed overflow (cOut); this guarantees correct results for M = 0x80000000.
REQ-018 The counter increments every RUN edge; the edge with counter=31 completes the 32nd iteration and moves to DONE.
REQ-019 DONE: data_resultRDY=1 for exactly that one cycle; the next edge returns to IDLE.
REQ-020 Latency: if start is sampled at edge N, RDY is high between edges N+32 and N+33.
REQ-021 data_result=Q[31:0] and data_exception=(U[31:0] is not all-equal to Q[31]). Both are registered at the DONE transition and held stable until the next accepted start.
REQ-022 ctrl_MULT=1 in RUN aborts the operation and reloads with new operands; counter=0; no RDY is generated for the aborted operation.
REQ-023 ctrl_MULT=1 in DONE: RDY still pulses that cycle, then the block enters RUN with the new operands (no IDLE cycle).
REQ-024 Operand inputs are ignored except on the accepted start edge.

Reset
REQ-025 While reset=1 at an edge: state=IDLE, counter=0, P=0, M=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-026 Reset overrides ctrl_MULT on the same edge.
REQ-027 Reset mid-RUN discards the operation; no RDY pulse follows.

Structure
REQ-028 Shared package holds: WIDTH=32, ITER=32, counter width 5, state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
REQ-029 Exactly one sub-module instance: thirty_two_bit_cla (A=U, B=M or ~M, cIn=subtract select). Its sum and cOut feed REQ-016/REQ-017.
REQ-030 Controller FSM, counter, and shift register live in booth_mult_ctrl; there are no additional sub-modules.

Verification
REQ-031 Basic multiply: A=3, B=4, start at edge 0 -> RDY only at cycle 32 to 33, result=12, exception=0, busy high for cycles 0 to 32.
REQ-032 Mixed signs: A=-7 (0xFFFFFFF9), B=6 -> result=0xFFFFFFD6 (-42), exception=0.
REQ-033 Overflow cases, each expecting exception=1:
- A=0x80000000, B=0xFFFFFFFF -> result=0x80000000.
- A=0x7FFFFFFF, B=2 -> result=0xFFFFFFFE.
- A=0x00010000, B=0x00010000 -> result=0.
REQ-034 Most-negative squared: A=0x80000000, B=0x80000000 -> result=0, exception=1. This checks the REQ-017 sign correction.
REQ-035 Restart: start A=5,B=5, then restart at cycle 10 with A=-1,B=-1 -> single RDY at cycle 42 to 43, result=1, exception=0.
REQ-036 Reset mid-run: start A=9,B=9, assert reset at cycle 15 -> all outputs 0 and no RDY for 40 cycles; a following start A=2,B=3 -> result=6.
